// File: rtl/dpd_fb_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dpd_fb_align : PA feedback loop-delay search by correlation, plus continuous
//                delay compensation of the feedback path.
// Revision     : 1.0
// ============================================================================
module dpd_fb_align #(
    parameter int MAX_D = 32,
    parameter int WIN   = 256,
    parameter int AW    = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [19:0] ref_i,
    input  logic signed [19:0] ref_q,
    input  logic signed [19:0] fb_i,
    input  logic signed [19:0] fb_q,
    output logic signed [19:0] fb_al_i,
    output logic signed [19:0] fb_al_q,
    output logic [5:0]         delay,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CW = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam int NW = $clog2(WIN + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ACC    = 3'd2,
        S_CMP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic signed [19:0]    ref_di [MAX_D];
    logic signed [19:0]    ref_dq [MAX_D];
    logic signed [19:0]    fb_di  [MAX_D];
    logic signed [19:0]    fb_dq  [MAX_D];
    logic [CW-1:0]         cand;
    logic [CW-1:0]         best_d;
    logic signed [40:0]    prod;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  best;
    logic [NW-1:0]         cnt;
    logic                  settle;
    logic [5:0]            tap;

    // Larger estimated delay selects a shallower feedback tap, keeping ref-to-fb_al latency fixed.
    assign tap = 6'(MAX_D - 1) - delay;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_D; k++) begin
                ref_di[k] <= '0;
                ref_dq[k] <= '0;
                fb_di[k]  <= '0;
                fb_dq[k]  <= '0;
            end
            fb_al_i <= '0;
            fb_al_q <= '0;
        end else begin
            ref_di[0] <= ref_i;
            ref_dq[0] <= ref_q;
            fb_di[0]  <= fb_i;
            fb_dq[0]  <= fb_q;
            for (int k = 1; k < MAX_D; k++) begin
                ref_di[k] <= ref_di[k-1];
                ref_dq[k] <= ref_dq[k-1];
                fb_di[k]  <= fb_di[k-1];
                fb_dq[k]  <= fb_dq[k-1];
            end
            fb_al_i <= fb_di[tap[CW-1:0]];
            fb_al_q <= fb_dq[tap[CW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= '0;
        end else begin
            prod <= 41'(fb_di[0]) * 41'(ref_di[cand]) + 41'(fb_dq[0]) * 41'(ref_dq[cand]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_SETTLE;
            end
            S_SETTLE: if (settle) state_nx = S_ACC;
            S_ACC:    if (cnt == NW'(WIN - 1)) state_nx = S_CMP;
            S_CMP:    state_nx = (cand == CW'(MAX_D - 1)) ? S_DONE : S_SETTLE;
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand   <= '0;
            best_d <= '0;
            best   <= '0;
            acc    <= '0;
            cnt    <= '0;
            settle <= 1'b0;
            delay  <= '0;
            err    <= 1'b0;
        end else begin
            // Two-cycle settle lets the product register pick up the new candidate tap.
            settle <= (state == S_SETTLE) ? ~settle : 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cand   <= '0;
                        best   <= '0;
                        best_d <= '0;
                        acc    <= '0;
                    end
                end
                S_SETTLE: cnt <= '0;
                S_ACC: begin
                    acc <= acc + AW'(prod);
                    cnt <= cnt + 1'b1;
                end
                S_CMP: begin
                    if (cand == '0 || acc > best) begin
                        best   <= acc;
                        best_d <= cand;
                    end
                    if (cand != CW'(MAX_D - 1)) begin
                        cand <= cand + 1'b1;
                        acc  <= '0;
                    end
                end
                S_DONE: begin
                    if (!best[AW-1] && best != '0) begin
                        delay <= 6'(best_d);
                        err   <= 1'b0;
                    end else begin
                        err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpd_fb_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dpd_fb_align : directed/randomized bench for dpd_fb_align with a
//                   correlation-search reference model.
// Revision        : 1.0
// ============================================================================
module tb_dpd_fb_align;

    localparam int MAX_D = 32;
    localparam int WIN   = 256;
    localparam int NDONE = MAX_D * (WIN + 3) + 1;
    localparam int HN    = 70000;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [19:0] ref_i = '0;
    logic signed [19:0] ref_q = '0;
    logic signed [19:0] fb_i  = '0;
    logic signed [19:0] fb_q  = '0;
    logic signed [19:0] fb_al_i;
    logic signed [19:0] fb_al_q;
    logic [5:0]         delay;
    logic               busy;
    logic               done;
    logic               err;

    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;

    int drv_ri [HN];
    int drv_rq [HN];
    int drv_fi [HN];
    int drv_fq [HN];

    int dly        = 0;
    int fsign      = 1;
    bit cst        = 1'b0;
    int cst_i      = 0;
    int cst_q      = 0;
    int prev_delay = 0;

    dpd_fb_align #(.MAX_D(MAX_D), .WIN(WIN), .AW(50)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ref_i   (ref_i),
        .ref_q   (ref_q),
        .fb_i    (fb_i),
        .fb_q    (fb_q),
        .fb_al_i (fb_al_i),
        .fb_al_q (fb_al_q),
        .delay   (delay),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus source: entry s holds what the DUT samples on rising edge number s.
    initial begin
        int s, ri, rq, fi, fq;
        logic [31:0] r;
        for (int k = 0; k < HN; k++) begin
            drv_ri[k] = 0; drv_rq[k] = 0; drv_fi[k] = 0; drv_fq[k] = 0;
        end
        forever begin
            @(negedge clk);
            s = cyc + 1;
            if (cst) begin
                ri = cst_i;
                rq = cst_q;
            end else begin
                r  = $urandom;
                ri = $signed(r[19:0]);
                r  = $urandom;
                rq = $signed(r[19:0]);
            end
            if (s < HN) begin
                drv_ri[s] = ri;
                drv_rq[s] = rq;
                fi = (s - dly >= 1) ? fsign * drv_ri[s-dly] : 0;
                fq = (s - dly >= 1) ? fsign * drv_rq[s-dly] : 0;
                drv_fi[s] = fi;
                drv_fq[s] = fq;
            end else begin
                fi = 0;
                fq = 0;
            end
            ref_i = 20'(ri);
            ref_q = 20'(rq);
            fb_i  = 20'(fi);
            fb_q  = 20'(fq);
        end
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Correlate registered feedback against the reference shifted by each candidate,
    // over the window of samples a search started on edge e0 accumulates.
    function automatic void model(input int e0, output int bd, output longint bb);
        longint a;
        int m;
        bd = 0;
        bb = 0;
        for (int c = 0; c < MAX_D; c++) begin
            a = 0;
            for (int j = 0; j < WIN; j++) begin
                m = e0 + c * (WIN + 3) + 1 + j;
                a += longint'(drv_fi[m]) * longint'(drv_ri[m-c])
                   + longint'(drv_fq[m]) * longint'(drv_rq[m-c]);
            end
            if (c == 0 || a > bb) begin
                bb = a;
                bd = c;
            end
        end
    endfunction

    task automatic run_search(input string tag, input int direct, input bit twice, input bit aligned);
        int     first, ndone, bd, e0, exp_d, exp_e;
        longint bb;
        e0    = cyc + 1;
        start = 1'b1;
        first = -1;
        ndone = 0;
        for (int i = 1; i <= NDONE + 20; i++) begin
            @(negedge clk);
            if (i == 1 || i == 101) start = 1'b0;
            if (twice && i == 100) start = 1'b1;
            if (i == 1) check({tag, " busy"}, busy, 1);
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        check({tag, " done_latency"}, first, NDONE);
        check({tag, " done_count"}, ndone, 1);
        model(e0, bd, bb);
        exp_d = (bb > 0) ? bd : prev_delay;
        exp_e = (bb > 0) ? 0 : 1;
        check({tag, " delay"}, delay, exp_d);
        check({tag, " err"}, err, exp_e);
        if (direct >= 0) check({tag, " delay_direct"}, delay, direct);
        prev_delay = exp_d;
        if (aligned) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check({tag, " fb_al_i"}, fb_al_i, drv_ri[cyc-MAX_D]);
                check({tag, " fb_al_q"}, fb_al_q, drv_rq[cyc-MAX_D]);
            end
        end
    endtask

    initial begin
        int nd;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst delay", delay, 0);
        check("rst fb_al_i", fb_al_i, 0);
        check("rst fb_al_q", fb_al_q, 0);
        reset = 1'b0;

        dly = 7;
        repeat (40) @(negedge clk);
        run_search("d7", 7, 1'b0, 1'b1);

        dly = 0;
        repeat (40) @(negedge clk);
        run_search("d0", 0, 1'b0, 1'b1);

        dly = 31;
        repeat (40) @(negedge clk);
        run_search("d31", 31, 1'b0, 1'b1);

        cst = 1'b1; cst_i = 1000; cst_q = -700; fsign = -1; dly = 5;
        repeat (40) @(negedge clk);
        run_search("neg", 31, 1'b0, 1'b0);
        check("neg err_direct", err, 1);

        cst_i = 1000; cst_q = 0; fsign = 1; dly = 0;
        repeat (40) @(negedge clk);
        run_search("tie", 0, 1'b0, 1'b0);

        cst = 1'b0; dly = 12;
        repeat (40) @(negedge clk);
        run_search("busy2", 12, 1'b1, 1'b1);

        dly = 20;
        repeat (40) @(negedge clk);
        start = 1'b1;
        nd = 0;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done === 1'b1) nd++;
        end
        reset = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst delay", delay, 0);
        check("midrst err", err, 0);
        check("midrst fb_al_i", fb_al_i, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("midrst no_done", nd, 0);
        reset = 1'b0;
        prev_delay = 0;
        run_search("restart", 20, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpd_fb_align.md
DPD_FB_ALIGN -- requirements
Module: dpd_fb_align

Interface
REQ-001 Parameter MAX_D, default 32: number of candidate loop delays searched, 0..MAX_D-1 clocks.
REQ-002 Parameter WIN, default 256: products accumulated per candidate delay.
REQ-003 Parameter AW, default 50: signed correlation accumulator width.
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that requests a delay search.
REQ-007 ref_i, ref_q  input  s20 each  transmitted reference (training) signal.
REQ-008 fb_i, fb_q  input  s20 each  raw PA feedback samples.
REQ-009 fb_al_i, fb_al_q  output  s20 each  delay-compensated feedback, feeding the DPD sig_pa port.
REQ-010 delay  output  u6  current estimated loop delay.
REQ-011 busy  output  1  high while a search is in progress.
REQ-012 done  output  1  one-cycle pulse when a search completes.
REQ-013 err  output  1  sticky flag: the last search found no positive correlation.

Function
REQ-014 The block SHALL register ref and fb on input, then keep a MAX_D-deep tapped delay line for each.
- ref_d[k] is the registered ref delayed k further clocks.
- fb_d[k] is the registered fb delayed k further clocks.
REQ-015 The block SHALL drive fb_al as the registered value of fb_d[MAX_D-1-delay].
- Latency from fb to fb_al is MAX_D-1-delay+2 clocks.
- When fb equals ref delayed by delay clocks, ref-to-fb_al latency is a constant MAX_D+1 clocks.
REQ-016 FSM states SHALL be IDLE, SETTLE, ACC, CMP, DONE.
REQ-017 IDLE:
- busy=0.
- start=1 clears cand, best, best_d and acc, then goes to SETTLE.
REQ-018 SETTLE SHALL last exactly 2 clocks (product pipeline refill), then go to ACC with the sample counter cleared.
REQ-019 ACC SHALL add p = fb_i*ref_d[cand]_i + fb_q*ref_d[cand]_q to acc for exactly WIN consecutive clocks.
- p is 41-bit signed, full precision, registered once before accumulation.
- acc is sign-extended to AW and does not saturate.
- After WIN clocks, go to CMP.
REQ-020 CMP (one clock):
- If cand==0 or acc > best (strict), load best=acc and best_d=cand; ties keep the lower delay.
- Then, if cand==MAX_D-1, go to DONE.
- Otherwise increment cand, clear acc and go to SETTLE.
REQ-021 DONE (one clock):
- done=1.
- If best > 0: delay <= best_d and err <= 0.
- Otherwise: delay is unchanged and err <= 1.
- Then go to IDLE.
REQ-022 busy SHALL be 1 in SETTLE, ACC, CMP and DONE.
REQ-023 start asserted while busy=1 SHALL be ignored, with no restart.
REQ-024 Search duration from start to done SHALL be MAX_D*(WIN+3)+1 clocks; 8289 with the defaults.
REQ-025 delay SHALL change only in DONE, so fb_al steps by at most one delay change per search, exactly one clock after done.
REQ-026 The tapped delay lines and the fb_al path SHALL run continuously, independent of FSM state.

Reset
REQ-027 While reset=1, all of the following SHALL be 0:
- FSM in IDLE, delay, busy, done, err.
- acc, best, best_d, cand.
- All delay-line registers and fb_al.
REQ-028 Reset asserted mid-search SHALL abort the search immediately, with no done pulse, and delay returns to 0.
REQ-029 After reset deasserts, the first start SHALL be accepted on the first clock.

Verification
REQ-030 Aligned search, defaults: ref = random full-scale, fb = ref delayed 7 clocks, pulse start.
- Response: done exactly 8289 clocks later, delay=7, err=0.
- Thereafter fb_al equals ref delayed 33 clocks, bit-exact.
REQ-031 Boundaries:
- fb = ref delayed 0 -> delay=0.
- fb = ref delayed 31 -> delay=31.
- fb = -ref delayed 5 (all correlations <= 0) -> err=1 and delay keeps its prior value.
REQ-032 Tie handling: ref = constant (1000,0) and fb = (1000,0) make all candidates equal.
- Response: delay=0, err=0.
REQ-033 Start while busy: second start 100 clocks after the first.
- Response: single done at 8289 clocks after the first start, result unaffected.
REQ-034 Reset mid-search: reset pulse at clock 4000 of a search.
- Response: busy=0, delay=0, done never pulses.
- A new start then completes normally with the correct delay.
